muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, operation request, sampled on rising clk.
REQ-004 SHALL have port alu_op, input, 4, operation code using the `ALU_MUL / `ALU_DIV / `ALU_MOD encodings of decode.vh.
REQ-005 SHALL have ports op_a and op_b, input, 32 each, signed two's-complement operands (op_a dividend/multiplicand, op_b divisor/multiplier).
REQ-006 SHALL have port flush, input, 1, synchronous abort of any in-flight operation.
REQ-007 SHALL have port busy, output, 1, high while an operation iterates.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port result, output, 32, operation result.
REQ-010 SHALL have port div_by_zero, output, 1, qualifies done for DIV/MOD with op_b==0.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE, and only when alu_op is MUL, DIV or MOD; all other alu_op values SHALL be ignored, with the state unchanged.
REQ-013 SHALL latch alu_op and operand magnitudes/signs on the accepting edge; later changes to op_a/op_b/alu_op SHALL not affect the operation.
REQ-014 SHALL, on accept at edge N with a nonzero divisor or MUL, enter RUN with a 5-bit iteration counter at 0; busy SHALL be high in cycles N+1..N+32.
REQ-015 SHALL perform one shift-add (MUL) or one restoring shift-subtract (DIV/MOD) step per RUN cycle on unsigned magnitudes, for exactly 32 steps.
REQ-016 SHALL transition RUN->DONE when the counter reaches 31; done SHALL be high for exactly cycle N+33 only.
REQ-017 SHALL make result equal to the low 32 bits of the signed product for MUL.
REQ-018 SHALL make result the quotient truncated toward zero for DIV (negated if operand signs differ).
REQ-019 SHALL make result the remainder, with the sign of op_a, for MOD.
REQ-020 SHALL make result 32'h8000_0000 for DIV 32'h8000_0000 / -1, and 0 for the corresponding MOD, without any error flag.
REQ-021 SHALL, on DIV/MOD with op_b==0, skip RUN and go directly to DONE: done high at N+1, div_by_zero high in that same cycle, result 32'hFFFF_FFFF for DIV and op_a for MOD.
REQ-022 SHALL hold result stable from done until the next accepted start; div_by_zero SHALL be high only in cycles where done is high.
REQ-023 SHALL leave DONE for IDLE after one cycle, or for RUN/DONE directly if a valid start is present in DONE (back-to-back issue).
REQ-024 SHALL ignore start while in RUN, with no queueing.
REQ-025 SHALL, on flush high at any edge, go to IDLE with busy=0 and no done pulse; flush SHALL take priority over a simultaneous start, and result SHALL keep its previous value.
REQ-026 SHALL generate busy, done and div_by_zero from registered state only, with no combinational path from inputs.

Reset
REQ-027 SHALL, while rst_n is low, immediately force state=IDLE, counter=0, busy=0, done=0, div_by_zero=0 and result=0, independent of clk.
REQ-028 SHALL, on reset assertion mid-RUN, abandon the operation with no done pulse after release.
REQ-029 SHALL require a start after reset release before any done pulse.

Verification
REQ-030 SHALL verify MUL: start, op_a=7, op_b=-3 at edge N -> busy high in cycles N+1..N+32, done in N+33, result=32'hFFFF_FFEB.
REQ-031 SHALL verify DIV and MOD signs: -7/2 -> 32'hFFFF_FFFD; -7 MOD 2 -> 32'hFFFF_FFFF; 7 MOD -2 -> 1.
REQ-032 SHALL verify divide by zero: DIV 5/0 -> done and div_by_zero at N+1, result 32'hFFFF_FFFF; MOD 5/0 -> result 5.
REQ-033 SHALL verify overflow: DIV 32'h8000_0000 / -1 -> result 32'h8000_0000, div_by_zero=0.
REQ-034 SHALL verify control: start with alu_op=MUL pulsed during RUN -> ignored, with a single done; flush at cycle N+10 -> busy 0 at N+11, no done; back-to-back start during DONE -> second done 33 cycles later.
REQ-035 SHALL verify reset: rst_n low at cycle N+15 -> all outputs 0 without a clock edge, and no done after release.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential 32-bit signed multiply / divide / modulo unit.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes.
module muldiv_seq #(
  // Opcode encodings; must track ALU_MUL / ALU_DIV / ALU_MOD in decode.vh
  parameter logic [3:0] ALU_MUL = 4'd8,
  parameter logic [3:0] ALU_DIV = 4'd9,
  parameter logic [3:0] ALU_MOD = 4'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_MOD} kind_t;

  state_t      state;
  kind_t       kind;
  logic [4:0]  cnt;
  logic        neg_res, neg_a;
  // a_reg: multiplicand / dividend-then-quotient, b_reg: multiplier / divisor,
  // acc: partial product / partial remainder
  logic [31:0] a_reg, b_reg, acc;

  logic        valid_op, accept, is_div_op;
  logic [31:0] mag_a, mag_b;
  assign valid_op  = (alu_op == ALU_MUL) || (alu_op == ALU_DIV) || (alu_op == ALU_MOD);
  assign accept    = start && valid_op && (state != RUN);
  assign is_div_op = (alu_op != ALU_MUL);
  assign mag_a     = op_a[31] ? -op_a : op_a;
  assign mag_b     = op_b[31] ? -op_b : op_b;

  logic [32:0] trial;
  logic [31:0] nxt_acc, nxt_a, nxt_b, fin;
  always_comb begin
    nxt_acc = acc;
    nxt_a   = a_reg;
    nxt_b   = b_reg;
    trial   = '0;
    if (kind == K_MUL) begin
      nxt_acc = b_reg[0] ? acc + a_reg : acc;
      nxt_a   = a_reg << 1;
      nxt_b   = b_reg >> 1;
    end else begin
      // partial remainder < divisor <= 2^31, so the shifted value fits in 32 bits
      trial   = {1'b0, acc[31:0], a_reg[31]} - {1'b0, b_reg};
      nxt_acc = trial[32] ? {acc[30:0], a_reg[31]} : trial[31:0];
      nxt_a   = {a_reg[30:0], ~trial[32]};
    end
  end

  always_comb begin
    case (kind)
      K_MUL:   fin = neg_res ? -nxt_acc : nxt_acc;
      K_DIV:   fin = neg_res ? -nxt_a   : nxt_a;
      default: fin = neg_a   ? -nxt_acc : nxt_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kind        <= K_MUL;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_a       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        RUN: begin
          acc   <= nxt_acc;
          a_reg <= nxt_a;
          b_reg <= nxt_b;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin;
          end
        end
        default: begin
          if (accept) begin
            kind    <= (alu_op == ALU_MUL) ? K_MUL : (alu_op == ALU_DIV) ? K_DIV : K_MOD;
            neg_res <= op_a[31] ^ op_b[31];
            neg_a   <= op_a[31];
            a_reg   <= mag_a;
            b_reg   <= mag_b;
            acc     <= '0;
            cnt     <= '0;
            if (is_div_op && op_b == 32'd0) begin
              // divide by zero bypasses iteration entirely
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              result      <= (alu_op == ALU_DIV) ? 32'hFFFF_FFFF : op_a;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
